temp_sampler: RTL and testbench
===============================

Name: temp_sampler

Overview:
- Upstream front end of the thermostat controller.
- Periodically requests a reading from the SPI handler's thermometer port and captures the 10-bit Celsius result.
- Smooths readings with a 4-sample rounded average, converts to °F or °C per i_use_f, and drives the controller's ufixed 7.2 temperature input.
- Flags a fault when the SPI handler fails to answer within a timeout.

Parameters:
- g_sample_period, 10000, clocks between request launches (0.5 s at 20 kHz).
- g_timeout, 4000, max clocks from request to i_therm_ready before fault.
- g_div_steps, 14, iterations of the sequential divider; equals the numerator width.

Ports:
- i_clk  in  1  system clock (20 kHz).
- i_reset  in  1  asynchronous, active-high reset.
- i_use_f  in  1  1 = output °F, 0 = output °C.
- o_read_therm  out  1  temperature request to SPI handler.
- i_therm_ready  in  1  SPI handler result valid.
- i_spi_temperature  in  10  Celsius reading, unsigned Q8.2.
- o_temperature  out  9  ufixed 7.2 temperature, bits [6:-2], to controller.
- o_temp_valid  out  1  one-cycle pulse when o_temperature updates.
- o_fault  out  1  sticky timeout flag.

Behaviour:
- Reset values: o_read_therm=0, o_temperature=0, o_temp_valid=0, o_fault=0, average buffer empty.
- Period counter:
  - free-running 0..g_sample_period-1; starts at g_sample_period-1 so the first tick comes on the first cycle after reset release.
  - tick = counter at max.
  - A tick arriving while the FSM is not IDLE is dropped, never queued.
- FSM states IDLE, REQ, CONV, OUT:
  - IDLE: on tick, set o_read_therm=1, clear timeout counter, go to REQ.
  - REQ:
    - o_read_therm held 1. On the first edge with i_therm_ready=1, capture i_spi_temperature (call this edge C0), drop o_read_therm at the same edge, clear o_fault, go to CONV.
    - If i_therm_ready is not seen within g_timeout cycles, drop o_read_therm, set o_fault, return to IDLE. Buffer and o_temperature are not changed.
  - CONV: average and conversion, then go to OUT.
  - OUT: load o_temperature and pulse o_temp_valid for one cycle, go to IDLE.
- Averaging:
  - 4-entry shift buffer; the first sample after reset fills all 4 entries (no startup ramp).
  - avg = (sum + 2) >> 2, sum 12 bits, result 10 bits Q8.2.
- Conversion, quarter-degree units:
  - °F: num = 9*avg + 2 (14 bits); q = num / 5 on a restoring divider, g_div_steps cycles; F = q + 128.
  - °C: value = avg.
  - Both modes saturate to 511 (127.75) if the result exceeds 511.
  - °C mode still runs the divider, so latency is mode-independent.
  - i_use_f is sampled once, at C0.
- Latency:
  - average registered at C0+1, divider starts at C0+1 and completes at C0+15.
  - o_temperature and o_temp_valid update at edge C0+16.
- i_therm_ready high while in IDLE: ignored.
- Reset mid-transaction: immediate return to reset values; any in-flight division is discarded.

Decomposition:
- Package temp_sampler_pkg holds:
  - FSM state encoding;
  - constants: F offset 128 (32 °F × 4), saturation max 511, multiplier 9, divisor 5, rounding term 2.
- Sub-module seq_divider: 14-bit dividend, 3-bit divisor, start/done handshake, g_div_steps iterations.
- seq_divider is instantiated once.

Test Plan:
- Reset, i_use_f=1, SPI model returns 80 (20.0 °C) -> o_read_therm rises at the first cycle after reset; o_temperature=272 (68.0 °F) with o_temp_valid exactly 16 cycles after the capture edge.
- Steady readings of 102 (25.5 °C) -> 312 (78.0 °F). Switch i_use_f=0 with reading 88 -> next output 88 (22.0 °C); with i_use_f=1 the same reading gives 286 (71.5 °F).
- Averaging, buffer primed with 80, then readings 96, 96, 96, 96 -> outputs after each in °C mode: 84, 88, 92, 96.
- Saturation: reading 240 (60 °C) in °F -> 511; reading 520 in °C -> 511.
- Timeout: model never asserts i_therm_ready -> o_read_therm drops and o_fault=1 at request+g_timeout, o_temperature unchanged. The next successful read clears o_fault.
- Reset asserted mid-divide -> all outputs 0 and no o_temp_valid pulse. After release, a fresh request is issued on the first cycle.

Source files
------------

// File: rtl/temp_sampler_pkg.sv
// Shared types and constants for the thermometer sampling front end.
// Holds the FSM encoding, conversion constants and the output saturation helper.
package temp_sampler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CONV,
    S_OUT
  } state_t;

  localparam int C_TW = 10;
  localparam int C_OW = 9;
  localparam int C_NW = 14;
  localparam int C_DW = 3;

  localparam int unsigned C_F_OFFSET = 128;
  localparam int unsigned C_SAT_MAX  = 511;
  localparam int unsigned C_MUL      = 9;
  localparam int unsigned C_DIV      = 5;
  localparam int unsigned C_RND      = 2;

  function automatic logic [C_OW-1:0] sat9(input logic [C_NW-1:0] v);
    return (v > C_NW'(C_SAT_MAX)) ? C_OW'(C_SAT_MAX) : v[C_OW-1:0];
  endfunction

endpackage

// File: rtl/temp_sampler_div.sv
// Restoring divider: one quotient bit per clock after a start pulse.
// o_done pulses for one cycle once the final bit has been produced.
module seq_divider
  import temp_sampler_pkg::*;
#(
  parameter int g_div_steps = 14
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [C_NW-1:0] i_dividend,
  input  logic [C_DW-1:0] i_divisor,
  output logic [C_NW-1:0] o_quotient,
  output logic            o_done
);

  localparam int CW = $clog2(g_div_steps + 1);

  logic [C_NW-1:0] r_q;
  logic [C_DW-1:0] r_rem;
  logic [C_DW-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic [C_DW:0]   w_sh;
  logic [C_DW:0]   w_diff;
  logic            w_ge;

  // remainder stays below the divisor, so it always fits C_DW bits
  assign w_sh   = {r_rem, r_q[C_NW-1]};
  assign w_ge   = (w_sh >= {1'b0, r_div});
  assign w_diff = w_sh - {1'b0, r_div};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_q    <= i_dividend;
        r_rem  <= '0;
        r_div  <= i_divisor;
        r_cnt  <= CW'(g_div_steps);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_q   <= {r_q[C_NW-2:0], w_ge};
        r_rem <= w_ge ? w_diff[C_DW-1:0] : w_sh[C_DW-1:0];
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_quotient = r_q;
  assign o_done     = r_done;

endmodule

// File: rtl/temp_sampler.sv
// Periodic thermometer reader: request, 4-sample rounded average, C/F conversion.
// A missing SPI answer within the timeout raises a sticky fault.
module temp_sampler
  import temp_sampler_pkg::*;
#(
  parameter int g_sample_period = 10000,
  parameter int g_timeout       = 4000,
  parameter int g_div_steps     = 14
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_use_f,
  output logic            o_read_therm,
  input  logic            i_therm_ready,
  input  logic [C_TW-1:0] i_spi_temperature,
  output logic [C_OW-1:0] o_temperature,
  output logic            o_temp_valid,
  output logic            o_fault
);

  localparam int PW = $clog2(g_sample_period + 1);
  localparam int TW = $clog2(g_timeout + 1);

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]   r_per;
  logic [TW-1:0]   r_to;
  logic [C_TW-1:0] r_buf [4];
  logic            r_buf_vld;
  logic            r_use_f;
  logic            r_start;
  logic [C_TW-1:0] r_avg;
  logic            r_read;
  logic            r_fault;
  logic            r_valid;
  logic [C_OW-1:0] r_temp;

  logic            w_tick;
  logic            w_launch;
  logic            w_capture;
  logic            w_timeout;
  logic            w_load;
  logic [11:0]     w_sum;
  logic [11:0]     w_rnd;
  logic [C_TW-1:0] w_avg;
  logic [C_NW-1:0] w_num;
  logic [C_NW-1:0] w_quot;
  logic            w_div_done;

  assign w_tick = (r_per == PW'(g_sample_period - 1));

  assign w_sum = 12'(r_buf[0]) + 12'(r_buf[1])
               + 12'(r_buf[2]) + 12'(r_buf[3]);
  assign w_rnd = w_sum + 12'(C_RND);
  assign w_avg = w_rnd[11:2];
  assign w_num = C_NW'(C_MUL) * {4'b0, w_avg} + C_NW'(C_RND);

  seq_divider #(
    .g_div_steps(g_div_steps)
  ) u_div (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (r_start),
    .i_dividend(w_num),
    .i_divisor (C_DW'(C_DIV)),
    .o_quotient(w_quot),
    .o_done    (w_div_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_launch = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        if (i_therm_ready) begin
          w_capture = 1'b1;
          w_next    = S_CONV;
        end else if (r_to == TW'(g_timeout - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_CONV: begin
        if (w_div_done) begin
          w_load = 1'b1;
          w_next = S_OUT;
        end
      end
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_per     <= PW'(g_sample_period - 1);
      r_to      <= '0;
      r_buf     <= '{default: '0};
      r_buf_vld <= 1'b0;
      r_use_f   <= 1'b0;
      r_start   <= 1'b0;
      r_avg     <= '0;
      r_read    <= 1'b0;
      r_fault   <= 1'b0;
      r_valid   <= 1'b0;
      r_temp    <= '0;
    end else begin
      r_per   <= w_tick ? '0 : r_per + 1'b1;
      r_start <= w_capture;
      r_valid <= w_load;
      if (w_launch) begin
        r_read <= 1'b1;
        r_to   <= '0;
      end else if (r_state == S_REQ) begin
        r_to <= r_to + 1'b1;
      end
      if (w_capture || w_timeout) r_read <= 1'b0;
      if (w_timeout) r_fault <= 1'b1;
      if (w_capture) begin
        r_fault   <= 1'b0;
        r_use_f   <= i_use_f;
        r_buf_vld <= 1'b1;
        // first sample after reset primes every slot
        for (int k = 0; k < 4; k++) begin
          if (!r_buf_vld || k == 0) r_buf[k] <= i_spi_temperature;
          else                      r_buf[k] <= r_buf[k-1];
        end
      end
      if (r_start) r_avg <= w_avg;
      if (w_load) begin
        r_temp <= r_use_f ? sat9(w_quot + C_NW'(C_F_OFFSET))
                          : sat9({4'b0, r_avg});
      end
    end
  end

  assign o_read_therm  = r_read;
  assign o_fault       = r_fault;
  assign o_temp_valid  = r_valid;
  assign o_temperature = r_temp;

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: SPI responder, timestamp-based reference model,
// per-cycle compare plus directed literal expectations.
module tb_temp_sampler;

  localparam int P   = 60;
  localparam int T   = 20;
  localparam int LAT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       use_f = 1'b1;
  logic       rdy = 1'b0;
  logic [9:0] spi = '0;
  logic       rd;
  logic       vld;
  logic       flt;
  logic [8:0] temp;

  always #5 clk = ~clk;

  temp_sampler #(
    .g_sample_period(P),
    .g_timeout      (T),
    .g_div_steps    (14)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_use_f          (use_f),
    .o_read_therm     (rd),
    .i_therm_ready    (rdy),
    .i_spi_temperature(spi),
    .o_temperature    (temp),
    .o_temp_valid     (vld),
    .o_fault          (flt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output from the running sum of the last four readings.
  function automatic int expect_temp(input int sum, input bit f);
    int avg;
    int v;
    avg = (sum + 2) / 4;
    v = f ? (9 * avg + 2) / 5 + 128 : avg;
    return (v > 511) ? 511 : v;
  endfunction

  // Reference model: timestamps in edges since reset release.
  int e, req_e, pend_e, free_e, cap_e, pend_v, m_temp;
  bit m_req, m_flt, m_vld;
  int hist[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      e = 0; m_req = 0; m_flt = 0; m_vld = 0; m_temp = 0;
      pend_e = -1; free_e = 0; cap_e = 0;
      hist.delete();
    end else begin
      int sum;
      e++;
      m_vld = 0;
      if (pend_e == e) begin
        m_temp = pend_v; m_vld = 1; pend_e = -1;
      end
      if (m_req) begin
        if (rdy) begin
          if (hist.size() == 0)
            repeat (4) hist.push_front(int'(spi));
          else begin
            hist.push_front(int'(spi));
            void'(hist.pop_back());
          end
          sum = 0;
          foreach (hist[k]) sum += hist[k];
          pend_v = expect_temp(sum, use_f);
          pend_e = e + LAT;
          free_e = e + LAT + 2;
          cap_e = e;
          m_req = 0;
          m_flt = 0;
        end else if (e - req_e == T) begin
          m_req = 0; m_flt = 1; free_e = e + 1;
        end
      end else if ((e - 1) % P == 0 && e >= free_e) begin
        m_req = 1; req_e = e;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("read_therm", 32'(rd), 32'(m_req));
    chk("temp_valid", 32'(vld), 32'(m_vld));
    chk("temperature", 32'(temp), m_temp);
    chk("fault", 32'(flt), 32'(m_flt));
  end

  // SPI handler model
  bit silent = 0, rand_mode = 0, spur = 0, silent_now = 0, prev_rd = 0;
  int wait_c = -1;
  int fq[$];

  initial forever begin
    @(negedge clk);
    if (rd && !prev_rd) begin
      wait_c = $urandom_range(0, 6);
      silent_now = rand_mode ? ($urandom % 8 == 0) : silent;
    end
    prev_rd = rd;
    rdy = 1'b0;
    if (rd) begin
      if (!silent_now) begin
        if (wait_c == 0) begin
          rdy = 1'b1;
          spi = (fq.size() > 0) ? 10'(fq.pop_front())
                                : 10'($urandom_range(0, 1023));
          wait_c = -1;
        end else if (wait_c > 0) wait_c--;
      end
    end else if (spur && $urandom % 6 == 0) begin
      rdy = 1'b1;
      spi = 10'($urandom_range(0, 1023));
    end
  end

  task automatic wait_out(input string name, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld && n < 300);
    if (!vld) begin
      checks++;
      failures++;
      $display("FAIL %s: no o_temp_valid within %0d cycles", name, n);
    end else begin
      if (exp >= 0) chk(name, 32'(temp), exp);
      chk({name, "_lat"}, e - cap_e, LAT);
    end
  endtask

  task automatic wait_rd(input string name, input bit lvl, output int n);
    n = 0;
    while (rd !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rd !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s: read_therm never reached %0d", name, lvl);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    int exp_avg[4] = '{84, 88, 92, 96};
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(rd), 0);
    chk("rst_temp", 32'(temp), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_fault", 32'(flt), 0);

    fq.push_back(80);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(rd), 1);
    wait_out("f68", 272);

    repeat (4) fq.push_back(102);
    repeat (3) wait_out("mix102", -1);
    wait_out("f78", 312);

    use_f = 1'b0;
    repeat (4) fq.push_back(88);
    repeat (3) wait_out("mix88", -1);
    wait_out("c22", 88);
    use_f = 1'b1;
    fq.push_back(88);
    wait_out("f71_5", 286);

    pulse_reset();
    use_f = 1'b0;
    fq.push_back(80);
    wait_out("prime80", 80);
    for (int i = 0; i < 4; i++) begin
      fq.push_back(96);
      wait_out("avg96", exp_avg[i]);
    end

    pulse_reset();
    use_f = 1'b1;
    fq.push_back(240);
    wait_out("sat_f", 511);
    pulse_reset();
    use_f = 1'b0;
    fq.push_back(520);
    wait_out("sat_c", 511);

    silent = 1;
    wait_rd("to_req", 1'b1, n);
    wait_rd("to_drop", 1'b0, n);
    chk("timeout_len", n, T);
    chk("timeout_fault", 32'(flt), 1);
    chk("timeout_temp", 32'(temp), 511);
    silent = 0;
    fq.push_back(80);
    wait_out("post_fault", 410);
    chk("fault_clear", 32'(flt), 0);

    fq.push_back(100);
    wait_rd("md_req", 1'b1, n);
    wait_rd("md_cap", 1'b0, n);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("md_read", 32'(rd), 0);
    chk("md_temp", 32'(temp), 0);
    chk("md_fault", 32'(flt), 0);
    repeat (20) begin
      @(negedge clk);
      chk("md_novalid", 32'(vld), 0);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    chk("md_fresh_req", 32'(rd), 1);
    wait_out("md_after", -1);

    rand_mode = 1;
    spur = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom % 37 == 0) use_f = 1'($urandom);
      if ($urandom % 1500 == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    rand_mode = 0;
    spur = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
